// File: rtl/ika87ad_irq_arbiter.sv
// Interrupt arbiter: picks the highest-priority eligible source at an instruction boundary,
// holds the request until the core accepts or IE withdraws it, then emits one tick of acks.
module ika87ad_irq_arbiter (
  input  logic        i_EMUCLK,
  input  logic        i_MRST_n,
  input  logic        i_CEN,
  input  logic [10:0] i_IFLAG,
  input  logic [10:0] i_MASK,
  input  logic        i_IE,
  input  logic        i_BOUNDARY,
  input  logic        i_ACCEPT,
  input  logic        i_SKIT,
  input  logic [4:0]  i_SKIT_CODE,
  output logic        o_IRQ_REQ,
  output logic [15:0] o_VECTOR,
  output logic [10:0] o_AUTO_ACK,
  output logic        o_MANUAL_ACK,
  output logic [4:0]  o_MANUAL_CODE,
  output logic [10:0] o_MULTI,
  output logic        o_IE_CLR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_idx;
  logic [15:0] r_vector;
  logic [10:0] r_auto_ack;
  logic        r_ie_clr;
  logic        r_manual_ack;
  logic [4:0]  r_manual_code;

  logic [10:0] w_elig;
  logic [3:0]  w_win;
  logic [15:0] w_win_vec;
  logic        w_latch;
  logic        w_accept;
  logic [10:0] w_ack_onehot;

  // Both sources of a pair must be unmasked for the group to run in multi-IRQ mode.
  always_comb begin
    o_MULTI = '0;
    for (int g = 0; g < 5; g++) begin
      o_MULTI[2*g+1] = ~i_MASK[2*g+1] & ~i_MASK[2*g+2];
      o_MULTI[2*g+2] = ~i_MASK[2*g+1] & ~i_MASK[2*g+2];
    end
  end

  assign w_elig = i_IFLAG & ~(i_MASK & 11'h7FE) & {{10{i_IE}}, 1'b1};

  // Scan downward so the lowest eligible index is the last one written.
  always_comb begin
    w_win = 4'd0;
    for (int k = 10; k >= 0; k--) begin
      if (w_elig[k]) w_win = 4'(k);
    end
  end

  always_comb begin
    case (w_win)
      4'd0:          w_win_vec = 16'h0004;
      4'd1, 4'd2:    w_win_vec = 16'h0008;
      4'd3, 4'd4:    w_win_vec = 16'h0010;
      4'd5, 4'd6:    w_win_vec = 16'h0018;
      4'd7, 4'd8:    w_win_vec = 16'h0020;
      default:       w_win_vec = 16'h0028;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_BOUNDARY && (|w_elig)) begin
          w_state_nxt = S_REQ;
          w_latch     = 1'b1;
        end
      end
      S_REQ: begin
        if (i_ACCEPT) begin
          w_state_nxt = S_ACK;
          w_accept    = 1'b1;
        end else if (!i_IE && (r_idx != 4'd0)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NMI never has a multi bit, so it is always auto-acknowledged.
  assign w_ack_onehot = (11'd1 << r_idx) & ~o_MULTI;

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      r_state       <= S_IDLE;
      r_idx         <= 4'd0;
      r_vector      <= 16'h0000;
      r_auto_ack    <= '0;
      r_ie_clr      <= 1'b0;
      r_manual_ack  <= 1'b0;
      r_manual_code <= 5'd0;
    end else if (i_CEN) begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_idx    <= w_win;
        r_vector <= w_win_vec;
      end
      r_auto_ack    <= w_accept ? w_ack_onehot : 11'd0;
      r_ie_clr      <= w_accept;
      r_manual_ack  <= i_SKIT;
      r_manual_code <= i_SKIT ? i_SKIT_CODE : 5'd0;
    end
  end

  assign o_IRQ_REQ     = (r_state == S_REQ);
  assign o_VECTOR      = r_vector;
  assign o_AUTO_ACK    = r_auto_ack;
  assign o_IE_CLR      = r_ie_clr;
  assign o_MANUAL_ACK  = r_manual_ack;
  assign o_MANUAL_CODE = r_manual_code;

endmodule

// File: tb/tb_ika87ad_irq_arbiter.sv
// Directed bench for the interrupt arbiter: a priority/vector table plus multi-cycle sequences.
module tb_ika87ad_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic [10:0] iflag = '0;
  logic [10:0] mask = '0;
  logic        ie = 1'b0;
  logic        boundary = 1'b0;
  logic        accept = 1'b0;
  logic        skit = 1'b0;
  logic [4:0]  skit_code = '0;
  logic        irq_req;
  logic [15:0] vector;
  logic [10:0] auto_ack;
  logic        manual_ack;
  logic [4:0]  manual_code;
  logic [10:0] multi;
  logic        ie_clr;

  int n_chk = 0;
  int n_fail = 0;

  ika87ad_irq_arbiter dut (
    .i_EMUCLK     (clk),
    .i_MRST_n     (rst_n),
    .i_CEN        (cen),
    .i_IFLAG      (iflag),
    .i_MASK       (mask),
    .i_IE         (ie),
    .i_BOUNDARY   (boundary),
    .i_ACCEPT     (accept),
    .i_SKIT       (skit),
    .i_SKIT_CODE  (skit_code),
    .o_IRQ_REQ    (irq_req),
    .o_VECTOR     (vector),
    .o_AUTO_ACK   (auto_ack),
    .o_MANUAL_ACK (manual_ack),
    .o_MANUAL_CODE(manual_code),
    .o_MULTI      (multi),
    .o_IE_CLR     (ie_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] iflag;
    logic [10:0] mask;
    logic        ie;
    logic        exp_req;
    logic [15:0] exp_vec;
    logic [10:0] exp_multi;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cen = 1'b1; iflag = '0; mask = '0; ie = 1'b0; boundary = 1'b0;
    accept = 1'b0; skit = 1'b0; skit_code = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic latch(input logic [10:0] f, input logic [10:0] m, input logic e);
    do_reset();
    iflag = f; mask = m; ie = e; boundary = 1'b1;
    tick();
    boundary = 1'b0;
  endtask

  initial begin
    tbl[0] = '{11'h018, 11'h000, 1'b1, 1'b1, 16'h0010, 11'h7FE};
    tbl[1] = '{11'h002, 11'h004, 1'b1, 1'b1, 16'h0008, 11'h7F8};
    tbl[2] = '{11'h401, 11'h000, 1'b0, 1'b1, 16'h0004, 11'h7FE};
    tbl[3] = '{11'h400, 11'h000, 1'b0, 1'b0, 16'h0000, 11'h7FE};
    tbl[4] = '{11'h600, 11'h200, 1'b1, 1'b1, 16'h0028, 11'h1FE};
    tbl[5] = '{11'h7FE, 11'h7FE, 1'b1, 1'b0, 16'h0000, 11'h000};
    tbl[6] = '{11'h0C0, 11'h020, 1'b1, 1'b1, 16'h0018, 11'h79E};
    tbl[7] = '{11'h081, 11'h001, 1'b1, 1'b1, 16'h0004, 11'h7FE};
    tbl[8] = '{11'h100, 11'h080, 1'b1, 1'b1, 16'h0020, 11'h67E};

    #3;
    chk("rst_irq_req", 32'(irq_req), 32'd0);
    chk("rst_vector", 32'(vector), 32'd0);
    chk("rst_auto_ack", 32'(auto_ack), 32'd0);
    chk("rst_manual", 32'({manual_ack, manual_code}), 32'd0);
    chk("rst_ie_clr", 32'(ie_clr), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      latch(tbl[i].iflag, tbl[i].mask, tbl[i].ie);
      chk($sformatf("tbl%0d_req", i), 32'(irq_req), 32'(tbl[i].exp_req));
      chk($sformatf("tbl%0d_vec", i), 32'(vector), 32'(tbl[i].exp_vec));
      chk($sformatf("tbl%0d_multi", i), 32'(multi), 32'(tbl[i].exp_multi));
      chk($sformatf("tbl%0d_noack", i), 32'(auto_ack), 32'd0);
    end

    // Multi-group source: no auto ack, IE cleared for one tick.
    latch(11'h018, 11'h000, 1'b1);
    accept = 1'b1; tick(); accept = 1'b0;
    chk("g2_ack_req", 32'(irq_req), 32'd0);
    chk("g2_auto_ack", 32'(auto_ack), 32'd0);
    chk("g2_ie_clr", 32'(ie_clr), 32'd1);
    #4;
    chk("g2_ie_clr_hold", 32'(ie_clr), 32'd1);
    tick();
    chk("g2_ie_clr_end", 32'(ie_clr), 32'd0);
    chk("g2_idle_req", 32'(irq_req), 32'd0);

    // Single-mode source gets auto ack.
    latch(11'h002, 11'h004, 1'b1);
    accept = 1'b1; tick(); accept = 1'b0;
    chk("t0_auto_ack", 32'(auto_ack), 32'h002);
    chk("t0_multi1", 32'(multi[1]), 32'd0);
    tick();
    chk("t0_auto_ack_end", 32'(auto_ack), 32'd0);

    // NMI is not withdrawn by IE=0 and is always auto acked.
    latch(11'h401, 11'h000, 1'b0);
    iflag = 11'h001; tick();
    chk("nmi_no_withdraw", 32'(irq_req), 32'd1);
    chk("nmi_vec", 32'(vector), 32'h0004);
    accept = 1'b1; tick(); accept = 1'b0;
    chk("nmi_auto_ack", 32'(auto_ack), 32'h001);

    // IE drop withdraws a maskable request; a later ACCEPT in IDLE is ignored.
    latch(11'h200, 11'h000, 1'b1);
    chk("sr_vec", 32'(vector), 32'h0028);
    ie = 1'b0; tick();
    chk("sr_withdraw_req", 32'(irq_req), 32'd0);
    chk("sr_withdraw_ack", 32'(auto_ack), 32'd0);
    accept = 1'b1; tick(); accept = 1'b0;
    chk("sr_idle_accept_ack", 32'(auto_ack), 32'd0);
    chk("sr_idle_accept_ieclr", 32'(ie_clr), 32'd0);

    // ACCEPT wins over withdrawal on the same tick.
    latch(11'h200, 11'h000, 1'b1);
    ie = 1'b0; accept = 1'b1; tick(); accept = 1'b0;
    chk("acc_prio_ieclr", 32'(ie_clr), 32'd1);

    // Manual and auto ack together.
    latch(11'h080, 11'h100, 1'b1);
    accept = 1'b1; skit = 1'b1; skit_code = 5'd5; tick();
    accept = 1'b0; skit = 1'b0; skit_code = 5'd0;
    chk("both_auto", 32'(auto_ack), 32'h080);
    chk("both_manual", 32'(manual_ack), 32'd1);
    chk("both_code", 32'(manual_code), 32'd5);
    tick();
    chk("both_manual_end", 32'(manual_ack), 32'd0);
    chk("both_auto_end", 32'(auto_ack), 32'd0);

    // No preemption while requesting.
    latch(11'h400, 11'h000, 1'b1);
    iflag = 11'h001; tick();
    chk("nopreempt_vec", 32'(vector), 32'h0028);
    chk("nopreempt_req", 32'(irq_req), 32'd1);

    // CEN low freezes state.
    cen = 1'b0; accept = 1'b1; tick(); tick();
    chk("cen_hold_req", 32'(irq_req), 32'd1);
    chk("cen_hold_ack", 32'(ie_clr), 32'd0);
    cen = 1'b1; accept = 1'b0;

    // No latch while in ACK; next boundary latches.
    latch(11'h018, 11'h000, 1'b1);
    accept = 1'b1; tick(); accept = 1'b0;
    boundary = 1'b1; tick();
    chk("ack_no_latch", 32'(irq_req), 32'd0);
    tick();
    chk("relatch_req", 32'(irq_req), 32'd1);
    boundary = 1'b0;

    // Reset mid-REQ discards the request.
    latch(11'h008, 11'h000, 1'b1);
    rst_n = 1'b0; #1;
    chk("rst_req_irq", 32'(irq_req), 32'd0);
    chk("rst_req_vec", 32'(vector), 32'd0);
    #1; rst_n = 1'b1;
    iflag = '0; accept = 1'b1; tick(); accept = 1'b0;
    chk("rst_req_no_ack", 32'(auto_ack), 32'd0);
    chk("rst_req_no_ieclr", 32'(ie_clr), 32'd0);

    // Reset mid-ACK clears the ack at once.
    latch(11'h002, 11'h004, 1'b1);
    accept = 1'b1; tick(); accept = 1'b0;
    rst_n = 1'b0; #1;
    chk("rst_ack_auto", 32'(auto_ack), 32'd0);
    chk("rst_ack_ieclr", 32'(ie_clr), 32'd0);
    #1; rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ika87ad_irq_arbiter.md
IKA87AD_IRQ_ARBITER -- requirements
Module: IKA87AD_irqarbiter

Interface
REQ-001 SHALL have port i_EMUCLK  in  1  sole clock; all state SHALL change on its rising edge.
REQ-002 SHALL have port i_MRST_n  in  1  master reset; asynchronous, active-low.
REQ-003 SHALL have port i_CEN  in  1  tick enable; state and registered outputs SHALL update only on edges where i_CEN=1.
REQ-004 SHALL have port i_IFLAG  in  11  pending flags; index 0 NMI, 1 INTT0, 2 INTT1, 3 INT1, 4 INT2, 5 INTE0, 6 INTE1, 7 INTEIN, 8 INTAD, 9 INTSR, 10 INTST.
REQ-005 SHALL have port i_MASK  in  11  per-source mask; 1=masked; bit 0 ignored.
REQ-006 SHALL have port i_IE  in  1  global interrupt enable; NMI ignores it.
REQ-007 SHALL have port i_BOUNDARY  in  1  core is at an instruction boundary.
REQ-008 SHALL have port i_ACCEPT  in  1  core has taken the vector and pushed PC.
REQ-009 SHALL have port i_SKIT  in  1  SKIT/SKNIT clear request.
REQ-010 SHALL have port i_SKIT_CODE  in  5  source index to be cleared.
REQ-011 SHALL have port o_IRQ_REQ  out  1  interrupt request to core.
REQ-012 SHALL have port o_VECTOR  out  16  vector address of latched source.
REQ-013 SHALL have port o_AUTO_ACK  out  11  one-hot auto acknowledge to flags.
REQ-014 SHALL have port o_MANUAL_ACK  out  1  manual acknowledge strobe.
REQ-015 SHALL have port o_MANUAL_CODE  out  5  code accompanying o_MANUAL_ACK.
REQ-016 SHALL have port o_MULTI  out  11  per-source multi-IRQ-enabled indication.
REQ-017 SHALL have port o_IE_CLR  out  1  one-tick request to clear IE.

Function
REQ-018 Groups SHALL be G0={0}, G1={1,2}, G2={3,4}, G3={5,6}, G4={7,8}, G5={9,10}; vectors 0x0004, 0x0008, 0x0010, 0x0018, 0x0020, 0x0028.
REQ-019 o_MULTI SHALL be combinational: both bits of a two-source group set when both sources are unmasked, else 0; bit 0 always 0.
REQ-020 Eligible SHALL mean: source 0 when i_IFLAG[0]; source k>0 when i_IFLAG[k] & ~i_MASK[k] & i_IE.
REQ-021 The winner SHALL be the lowest-index eligible source (group order, then lower index within group).
REQ-022 FSM states SHALL be IDLE, REQ, ACK; encoded in 2 bits; unused encoding SHALL return to IDLE.
REQ-023 IDLE->REQ on a tick with i_BOUNDARY=1 and any eligible source; winner index and vector latched; o_IRQ_REQ=1 from the next cycle.
REQ-024 In REQ, the latched source and o_VECTOR SHALL stay frozen; a newly eligible higher-priority source SHALL NOT preempt.
REQ-025 In REQ, a tick with i_IE=0 and latched index non-zero, and i_ACCEPT=0, SHALL withdraw: ->IDLE, o_IRQ_REQ=0.
REQ-026 In REQ, a tick with i_ACCEPT=1 SHALL go ->ACK; i_ACCEPT has priority over withdrawal.
REQ-027 In ACK, for exactly one tick period: o_IRQ_REQ=0, o_IE_CLR=1, and o_AUTO_ACK has the latched index bit set only if that source's o_MULTI bit is 0 (NMI always).
REQ-028 ACK->IDLE unconditionally on the next tick; no new request SHALL be latched while in ACK.
REQ-029 A tick with i_SKIT=1 SHALL set o_MANUAL_ACK=1 and o_MANUAL_CODE=i_SKIT_CODE for one tick period, in any state.
REQ-030 Manual and auto acks in the same tick SHALL both be issued; neither SHALL be suppressed.
REQ-031 i_ACCEPT in IDLE or ACK SHALL be ignored.
REQ-032 o_AUTO_ACK, o_MANUAL_ACK and o_IE_CLR SHALL hold their value between ticks, so that a flag sampling on any tick-aligned strobe sees them.

Reset
REQ-033 On i_MRST_n=0, asynchronously: state=IDLE, o_IRQ_REQ=0, o_VECTOR=0x0000, o_AUTO_ACK=0, o_MANUAL_ACK=0, o_MANUAL_CODE=0, o_IE_CLR=0, latched index=0.
REQ-034 Reset asserted mid-REQ or mid-ACK SHALL discard the request with no ack emitted.

Verification
REQ-035 IFLAG=0x018, MASK=0, IE=1, BOUNDARY tick -> o_IRQ_REQ=1, o_VECTOR=0x0010; ACCEPT -> o_AUTO_ACK=0 (group multi), o_IE_CLR=1 one tick.
REQ-036 IFLAG=0x002, MASK=0x004, IE=1 -> o_VECTOR=0x0008; ACCEPT -> o_AUTO_ACK=0x002, o_MULTI[1]=0.
REQ-037 IFLAG=0x401, IE=0 -> vector 0x0004 latched; IFLAG=0x001 then raised in REQ with IE=0 -> no withdrawal; ACCEPT -> o_AUTO_ACK=0x001.
REQ-038 REQ latched on INTSR (0x028); IE cleared before ACCEPT -> o_IRQ_REQ=0 next tick, no o_AUTO_ACK, state IDLE.
REQ-039 SKIT with code 5 on the same tick ACK emits auto ack 0x080 -> o_MANUAL_ACK=1, o_MANUAL_CODE=5, o_AUTO_ACK=0x080 together.
REQ-040 i_MRST_n pulsed low in REQ -> all outputs 0 immediately, no ack after release.
